// File: rtl/matrix_window_ctrl_pkg.sv
// Shared types and helpers for the 3x3 matrix window controller.
// Holds the FSM state encoding and the counter width function.
package matrix_window_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      LINE  = 2'd2
   } win_state_t;

   // Index of the most significant set bit, i.e. floor(log2(value)) for value >= 1
   function automatic int log2b(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((value >> i) > 1) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/matrix_window_ctrl_if.sv
// Pixel-stream and matrix-side signal bundle for matrix_window_ctrl.
// master drives the incoming frame syncs, slave is the controller.
interface matrix_window_ctrl_if #(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480
);

   localparam int COL_W = matrix_window_ctrl_pkg::log2b(IMG_HDISP) + 1;
   localparam int ROW_W = matrix_window_ctrl_pkg::log2b(IMG_VDISP) + 1;

   logic             per_frame_vsync;
   logic             per_frame_href;
   logic             per_frame_clken;
   logic             ram_clken;
   logic             ram_href;
   logic [COL_W-1:0] col_cnt;
   logic [ROW_W-1:0] row_cnt;
   logic             matrix_frame_vsync;
   logic             matrix_frame_href;
   logic             matrix_frame_clken;
   logic             matrix_valid;
   logic             line_err;
   logic             frame_err;
   logic             frame_done;

   modport master (
      output per_frame_vsync,
      output per_frame_href,
      output per_frame_clken,
      input  ram_clken,
      input  ram_href,
      input  col_cnt,
      input  row_cnt,
      input  matrix_frame_vsync,
      input  matrix_frame_href,
      input  matrix_frame_clken,
      input  matrix_valid,
      input  line_err,
      input  frame_err,
      input  frame_done
   );

   modport slave (
      input  per_frame_vsync,
      input  per_frame_href,
      input  per_frame_clken,
      output ram_clken,
      output ram_href,
      output col_cnt,
      output row_cnt,
      output matrix_frame_vsync,
      output matrix_frame_href,
      output matrix_frame_clken,
      output matrix_valid,
      output line_err,
      output frame_err,
      output frame_done
   );

endinterface

// File: rtl/matrix_window_ctrl_sync_delay_line.sv
// Fixed-depth shift register used to re-time syncs and counters to the
// matrix pipeline; shifts every cycle, cleared by the async reset.
module sync_delay_line #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stages [DEPTH];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stages[i] <= '0;
         end
      end else begin
         stages[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign dout = stages[DEPTH-1];

endmodule

// File: rtl/matrix_window_ctrl.sv
// Sequencing controller for the two-line shift RAM and 3x3 matrix builder:
// tracks pixel position, gates the RAM, re-times syncs and flags bad geometry.
module matrix_window_ctrl
   import matrix_window_ctrl_pkg::*;
#(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480,
   parameter int PIPE_LAT  = 2
) (
   input  logic                 clock,
   input  logic                 rst_n,
   matrix_window_ctrl_if.slave  bus
);

   localparam int COL_W = log2b(IMG_HDISP) + 1;
   localparam int ROW_W = log2b(IMG_VDISP) + 1;
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_HDISP);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_VDISP);

   win_state_t       state;
   logic             vsync_d;
   logic             href_d;
   logic             vsync_armed;
   logic             vsync_rise;
   logic             vsync_fall;
   logic             href_rise;
   logic             href_fall;
   logic             ram_clken_c;
   logic             line_end;
   logic [COL_W-1:0] col_in;
   logic [COL_W-1:0] col_eff;
   logic [ROW_W-1:0] row_in;
   logic [ROW_W-1:0] row_eff;
   logic             line_err_q;
   logic             frame_err_q;
   logic             frame_done_q;
   logic [2:0]       sync_dly;
   logic [COL_W-1:0] col_dly;
   logic [ROW_W-1:0] row_dly;
   logic [COL_W-1:0] col_hold;
   logic [ROW_W-1:0] row_hold;
   logic             m_clken;

   // A frame only starts on a rise seen after vsync was low post-reset,
   // so a frame interrupted by reset is ignored until the next real start
   assign vsync_rise  = bus.per_frame_vsync & ~vsync_d & vsync_armed;
   assign vsync_fall  = ~bus.per_frame_vsync & vsync_d;
   assign href_rise   = bus.per_frame_href & ~href_d;
   assign href_fall   = ~bus.per_frame_href & href_d;
   assign ram_clken_c = bus.per_frame_href & bus.per_frame_clken & (state == LINE);
   assign line_end    = (state == LINE) & (href_fall | vsync_fall);

   // Column/row values including this cycle's pixel and line end, so the
   // line and frame checks see the counts as they will be after this edge
   always_comb begin
      col_eff = col_in;
      row_eff = row_in;
      if (ram_clken_c && (col_in != COL_MAX)) begin
         col_eff = col_in + COL_W'(1);
      end
      if (line_end && (row_in != ROW_MAX)) begin
         row_eff = row_in + ROW_W'(1);
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         vsync_d      <= 1'b0;
         href_d       <= 1'b0;
         vsync_armed  <= 1'b0;
         col_in       <= '0;
         row_in       <= '0;
         line_err_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         vsync_d      <= bus.per_frame_vsync;
         href_d       <= bus.per_frame_href;
         vsync_armed  <= vsync_armed | ~bus.per_frame_vsync;
         frame_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (vsync_rise) begin
                  state       <= FRAME;
                  col_in      <= '0;
                  row_in      <= '0;
                  line_err_q  <= 1'b0;
                  frame_err_q <= 1'b0;
               end
            end
            FRAME: begin
               if (vsync_fall) begin
                  state        <= IDLE;
                  frame_done_q <= 1'b1;
                  if (row_in != ROW_MAX) begin
                     frame_err_q <= 1'b1;
                  end
               end else if (href_rise) begin
                  state <= LINE;
               end
            end
            LINE: begin
               col_in <= col_eff;
               if (line_end) begin
                  col_in <= '0;
                  row_in <= row_eff;
                  if (col_eff != COL_MAX) begin
                     line_err_q <= 1'b1;
                  end
                  if (vsync_fall) begin
                     state        <= IDLE;
                     frame_done_q <= 1'b1;
                     if (row_eff != ROW_MAX) begin
                        frame_err_q <= 1'b1;
                     end
                  end else begin
                     state <= FRAME;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sync_delay_line #(
      .DEPTH (PIPE_LAT),
      .WIDTH (3)
   ) u_sync_dly (
      .clock (clock),
      .rst_n (rst_n),
      .din   ({bus.per_frame_vsync, bus.per_frame_href, ram_clken_c}),
      .dout  (sync_dly)
   );

   sync_delay_line #(
      .DEPTH (PIPE_LAT),
      .WIDTH (COL_W + ROW_W)
   ) u_cnt_dly (
      .clock (clock),
      .rst_n (rst_n),
      .din   ({col_in, row_in}),
      .dout  ({col_dly, row_dly})
   );

   assign m_clken = sync_dly[0];

   // Keep the last pixel's position visible through blanking and gaps
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         col_hold <= '0;
         row_hold <= '0;
      end else if (m_clken) begin
         col_hold <= col_dly;
         row_hold <= row_dly;
      end
   end

   assign bus.ram_clken          = ram_clken_c;
   assign bus.ram_href           = bus.per_frame_href & (state == LINE);
   assign bus.matrix_frame_vsync = sync_dly[2];
   assign bus.matrix_frame_href  = sync_dly[1];
   assign bus.matrix_frame_clken = m_clken;
   assign bus.col_cnt            = m_clken ? col_dly : col_hold;
   assign bus.row_cnt            = m_clken ? row_dly : row_hold;
   assign bus.matrix_valid       = m_clken & (row_dly >= ROW_W'(2)) & (col_dly >= COL_W'(2));
   assign bus.line_err           = line_err_q;
   assign bus.frame_err          = frame_err_q;
   assign bus.frame_done         = frame_done_q;

endmodule

// File: tb/tb_matrix_window_ctrl.sv
// Scoreboard bench for matrix_window_ctrl on an 8x4 image with a 2-cycle pipe:
// accepted pixels are queued with their expected position and matched at the output.
module tb_matrix_window_ctrl;

   localparam int H   = 8;
   localparam int V   = 4;
   localparam int LAT = 2;

   typedef struct {
      int col;
      int row;
      int valid;
      int cyc;
   } pix_t;

   logic clock = 1'b0;
   logic rst_n = 1'b0;

   matrix_window_ctrl_if #(.IMG_HDISP(H), .IMG_VDISP(V)) bus ();

   matrix_window_ctrl #(
      .IMG_HDISP (H),
      .IMG_VDISP (V),
      .PIPE_LAT  (LAT)
   ) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   pix_t sb [$];
   int   cyc = 0;
   int   tests_run = 0;
   int   tests_failed = 0;
   int   ram_count = 0;
   int   valid_count = 0;
   int   done_count = 0;
   bit   exp_ram = 1'b0;
   bit   exp_line_err = 1'b0;

   always @(posedge clock) cyc = cyc + 1;

   task automatic check_output(input string tag, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // Output side: RAM gating every cycle, scoreboard match on each matrix pixel
   always @(negedge clock) begin
      if (rst_n) begin
         check_output("ram_clken", int'(bus.ram_clken), int'(exp_ram));
         if (bus.ram_clken) ram_count++;
         if (bus.matrix_valid) valid_count++;
         if (bus.frame_done) done_count++;
         if (bus.matrix_frame_clken) begin
            if (sb.size() == 0) begin
               check_output("sb_underflow", 1, 0);
            end else begin
               pix_t e;
               e = sb.pop_front();
               check_output("col_cnt", int'(bus.col_cnt), e.col);
               check_output("row_cnt", int'(bus.row_cnt), e.row);
               check_output("matrix_valid", int'(bus.matrix_valid), e.valid);
               check_output("latency", cyc - e.cyc, LAT);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_ram_clken"}, int'(bus.ram_clken), 0);
      check_output({tag, "_ram_href"}, int'(bus.ram_href), 0);
      check_output({tag, "_col_cnt"}, int'(bus.col_cnt), 0);
      check_output({tag, "_row_cnt"}, int'(bus.row_cnt), 0);
      check_output({tag, "_m_vsync"}, int'(bus.matrix_frame_vsync), 0);
      check_output({tag, "_m_href"}, int'(bus.matrix_frame_href), 0);
      check_output({tag, "_m_clken"}, int'(bus.matrix_frame_clken), 0);
      check_output({tag, "_m_valid"}, int'(bus.matrix_valid), 0);
      check_output({tag, "_line_err"}, int'(bus.line_err), 0);
      check_output({tag, "_frame_err"}, int'(bus.frame_err), 0);
      check_output({tag, "_frame_done"}, int'(bus.frame_done), 0);
   endtask

   // One href window: a lead cycle for the FSM to enter LINE, then npix pixels
   task automatic drive_line(input int row, input int npix, input bit gaps);
      bus.per_frame_href  = 1'b1;
      bus.per_frame_clken = 1'b0;
      exp_ram = 1'b0;
      tick();
      for (int i = 0; i < npix; i++) begin
         bus.per_frame_clken = 1'b1;
         exp_ram = 1'b1;
         sb.push_back('{col: i, row: row, valid: ((row >= 2 && i >= 2) ? 1 : 0), cyc: cyc});
         tick();
         if (gaps) begin
            bus.per_frame_clken = 1'b0;
            exp_ram = 1'b0;
            tick();
         end
      end
      bus.per_frame_href  = 1'b0;
      bus.per_frame_clken = 1'b0;
      exp_ram = 1'b0;
      tick();
      if (npix != H) exp_line_err = 1'b1;
      check_output("line_err_after_line", int'(bus.line_err), int'(exp_line_err));
      tick();
      tick();
   endtask

   task automatic apply_stimulus(input int n_lines, input int short_line, input int short_len,
                                 input int gap_line);
      ram_count    = 0;
      valid_count  = 0;
      done_count   = 0;
      exp_line_err = 1'b0;
      bus.per_frame_vsync = 1'b1;
      tick();
      tick();
      check_output("line_err_cleared", int'(bus.line_err), 0);
      check_output("frame_err_cleared", int'(bus.frame_err), 0);
      for (int l = 0; l < n_lines; l++) begin
         drive_line(l, (l == short_line) ? short_len : H, (l == gap_line));
      end
      bus.per_frame_vsync = 1'b0;
      tick();
      tick();
      tick();
      check_output("frame_done_count", done_count, 1);
      check_output("line_err_end", int'(bus.line_err), int'(exp_line_err));
      check_output("frame_err_end", int'(bus.frame_err), (n_lines != V) ? 1 : 0);
   endtask

   initial begin
      bus.per_frame_vsync = 1'b0;
      bus.per_frame_href  = 1'b0;
      bus.per_frame_clken = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();
      tick();

      // Nominal frame
      apply_stimulus(V, -1, 0, -1);
      check_output("frameA_ram_count", ram_count, H * V);
      check_output("frameA_valid_count", valid_count, (V - 2) * (H - 2));

      // Second line one pixel short
      apply_stimulus(V, 1, H - 1, -1);

      // Only three lines, second line with clken gaps
      apply_stimulus(V - 1, -1, 0, 1);
      check_output("frameC_ram_count", ram_count, H * (V - 1));

      // Reset in the middle of the second line
      bus.per_frame_vsync = 1'b1;
      tick();
      tick();
      drive_line(0, H, 1'b0);
      bus.per_frame_href  = 1'b1;
      bus.per_frame_clken = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         bus.per_frame_clken = 1'b1;
         exp_ram = 1'b1;
         sb.push_back('{col: i, row: 1, valid: 0, cyc: cyc});
         tick();
      end
      rst_n = 1'b0;
      sb.delete();
      exp_ram = 1'b0;
      bus.per_frame_vsync = 1'b0;
      #1;
      check_all_zero("mid_reset");
      tick();
      tick();
      rst_n = 1'b1;
      done_count = 0;
      ram_count  = 0;
      for (int i = 0; i < 12; i++) begin
         bus.per_frame_clken = i[0];
         tick();
      end
      bus.per_frame_href  = 1'b0;
      bus.per_frame_clken = 1'b0;
      tick();
      tick();
      tick();
      check_all_zero("no_vsync");
      check_output("no_vsync_ram_count", ram_count, 0);
      check_output("no_vsync_done_count", done_count, 0);

      // Clean frame after the interrupted one
      apply_stimulus(V, -1, 0, -1);
      check_output("frameE_ram_count", ram_count, H * V);
      check_output("frameE_valid_count", valid_count, (V - 2) * (H - 2));
      check_output("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
